// File: rtl/pe_mac_cell.sv
// Processing element for a systolic array: multiply-accumulate cell that can
// run output-stationary (accumulate locally, then drain) or weight-stationary
// (hold a weight, add a*weight to the partial sum flowing down the column).
// Operands are forwarded east/south with one cycle of latency in every state.
module pe_mac_cell #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 1,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    input  logic              w_load,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_vld_in,
    input  logic              drain,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_vld_out,
    output logic [ACC_W-1:0]  acc,
    output logic [31:0]       mac_count,
    output logic              ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OS_RUN = 2'd1,
        WS_RUN = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    typedef struct packed {
        logic             ovf;
        logic [ACC_W-1:0] val;
    } add_t;

    state_t            state;
    state_t            state_nxt;
    state_t            eff_state;   // state whose rules apply to this cycle's inputs
    logic              quiet;
    logic              quiet_q;     // previous WS_RUN cycle was also quiet
    logic [DATA_W-1:0] weight;
    logic [DATA_W-1:0] mul_b;
    logic [ACC_W-1:0]  add_base;
    logic [ACC_W-1:0]  prod_ext;
    add_t              add_r;

    // Full-width product, sign- or zero-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] ext_product(input logic [DATA_W-1:0] x,
                                                     input logic [DATA_W-1:0] y);
        logic signed [2*DATA_W-1:0] sp;
        logic        [2*DATA_W-1:0] up;
        sp = (2*DATA_W)'($signed(x)) * (2*DATA_W)'($signed(y));
        up = (2*DATA_W)'(x) * (2*DATA_W)'(y);
        if (SIGNED != 0) ext_product = ACC_W'(sp);
        else             ext_product = ACC_W'(up);
    endfunction

    // Add with one guard bit; on overflow either clamp or keep the wrapped value.
    function automatic add_t add_clamp(input logic [ACC_W-1:0] x,
                                       input logic [ACC_W-1:0] y);
        logic [ACC_W:0]   ext_sum;
        logic [ACC_W-1:0] max_v;
        logic [ACC_W-1:0] min_v;
        add_t             r;
        if (SIGNED != 0) begin
            ext_sum = {x[ACC_W-1], x} + {y[ACC_W-1], y};
            r.ovf   = ext_sum[ACC_W] ^ ext_sum[ACC_W-1];
            max_v   = {1'b0, {(ACC_W-1){1'b1}}};
            min_v   = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            ext_sum = {1'b0, x} + {1'b0, y};
            r.ovf   = ext_sum[ACC_W];
            max_v   = '1;
            min_v   = '0;
        end
        r.val = ext_sum[ACC_W-1:0];
        // Signed: guard bit set means the true sum is negative. Unsigned can only overflow upward.
        if (r.ovf && SAT != 0)
            r.val = (SIGNED != 0 && ext_sum[ACC_W]) ? min_v : max_v;
        return r;
    endfunction

    assign busy = (state != IDLE);

    // Effective state: an IDLE cycle with valid input is handled as the run state it enters.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        eff_state = state;
        if (state == IDLE && (a_vld_in || b_vld_in || w_load))
            eff_state = mode ? WS_RUN : OS_RUN;
    end

    // Next-state logic; drain is only honoured once the cell is already in OS_RUN.
    always_comb begin
        state_nxt = eff_state;
        quiet     = !(a_vld_in || b_vld_in || w_load || psum_vld_in);
        case (eff_state)
            IDLE:    state_nxt = IDLE;
            OS_RUN:  if (drain && state == OS_RUN) state_nxt = DRAIN;
            WS_RUN:  if (quiet && quiet_q) state_nxt = IDLE;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared multiplier/adder: WS adds a*weight to the incoming psum, OS adds a*b to acc.
    always_comb begin
        mul_b    = (eff_state == WS_RUN) ? weight : b_in;
        add_base = (eff_state == WS_RUN) ? (psum_vld_in ? psum_in : '0) : acc;
        prod_ext = ext_product(a_in, mul_b);
        add_r    = add_clamp(add_base, prod_ext);
    end

    // State register and the WS_RUN quiet-cycle tracker.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) begin
            state   <= IDLE;
            quiet_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            quiet_q <= (eff_state == WS_RUN) && quiet && !quiet_q;
        end
    end

    // Datapath: forwarding, accumulate, weight capture, partial-sum output and drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out        <= '0;
            a_vld_out    <= 1'b0;
            b_out        <= '0;
            b_vld_out    <= 1'b0;
            psum_out     <= '0;
            psum_vld_out <= 1'b0;
            acc          <= '0;
            weight       <= '0;
            mac_count    <= '0;
            ovf          <= 1'b0;
        end else begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
            b_out     <= b_in;
            b_vld_out <= b_vld_in;
            case (eff_state)
                IDLE: psum_vld_out <= 1'b0;
                OS_RUN: begin
                    psum_out     <= psum_in;
                    psum_vld_out <= psum_vld_in;
                    if (a_vld_in && b_vld_in) begin
                        acc       <= add_r.val;
                        mac_count <= mac_count + 32'd1;
                        if (add_r.ovf) ovf <= 1'b1;
                    end
                end
                WS_RUN: begin
                    if (w_load) begin
                        weight       <= b_in;
                        psum_vld_out <= 1'b0;
                    end else if (a_vld_in) begin
                        psum_out     <= add_r.val;
                        psum_vld_out <= 1'b1;
                        acc          <= add_r.val;
                        mac_count    <= mac_count + 32'd1;
                        if (add_r.ovf) ovf <= 1'b1;
                    end else begin
                        psum_vld_out <= 1'b0;
                    end
                end
                DRAIN: begin
                    // An upstream psum arriving while we unload has nowhere to go: flag it.
                    psum_out     <= acc;
                    psum_vld_out <= 1'b1;
                    acc          <= '0;
                    if (psum_vld_in) ovf <= 1'b1;
                end
                default: psum_vld_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_cell.sv
// Bench for pe_mac_cell: four parameterisations share one stimulus stream; a
// behavioural model (plain integer arithmetic) predicts each cycle's outputs
// into a scoreboard queue that a separate monitor drains and compares.
module tb_pe_mac_cell;

    localparam int N = 4;
    localparam int AW [N] = '{24, 16, 16, 16};
    localparam int SG [N] = '{1, 1, 1, 0};
    localparam int ST [N] = '{1, 1, 0, 1};

    localparam int P_IDLE  = 0;
    localparam int P_OS    = 1;
    localparam int P_WS    = 2;
    localparam int P_DRAIN = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, a_vld_in, b_vld_in, w_load, psum_vld_in, drain;
    logic [7:0]  a_in, b_in;
    logic [23:0] psum_in;

    logic [7:0]  a_out_w [N];
    logic [7:0]  b_out_w [N];
    logic        a_vld_w [N];
    logic        b_vld_w [N];
    logic        pvld_w  [N];
    logic        ovf_w   [N];
    logic        busy_w  [N];
    logic [31:0] cnt_w   [N];
    logic [23:0] acc_w   [N];
    logic [23:0] psum_w  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = AW[g];
        logic [W-1:0] acc_l;
        logic [W-1:0] psum_l;
        pe_mac_cell #(.DATA_W(8), .ACC_W(W), .SIGNED(SG[g]), .SAT(ST[g])) u_dut (
            .clk          (clk),
            .rst          (rst),
            .mode         (mode),
            .a_in         (a_in),
            .a_vld_in     (a_vld_in),
            .b_in         (b_in),
            .b_vld_in     (b_vld_in),
            .w_load       (w_load),
            .psum_in      (psum_in[W-1:0]),
            .psum_vld_in  (psum_vld_in),
            .drain        (drain),
            .a_out        (a_out_w[g]),
            .a_vld_out    (a_vld_w[g]),
            .b_out        (b_out_w[g]),
            .b_vld_out    (b_vld_w[g]),
            .psum_out     (psum_l),
            .psum_vld_out (pvld_w[g]),
            .acc          (acc_l),
            .mac_count    (cnt_w[g]),
            .ovf          (ovf_w[g]),
            .busy         (busy_w[g])
        );
        assign acc_w[g]  = 24'(acc_l);
        assign psum_w[g] = 24'(psum_l);
    end

    typedef struct {
        int          st;
        longint      acc;
        longint      weight;
        int unsigned cnt;
        bit          ovf;
        bit          quiet;
        longint      psum;
        bit          pvld;
    } mdl_t;

    typedef struct {
        logic [7:0]  a;
        logic        av;
        logic [7:0]  b;
        logic        bv;
        longint      psum;
        logic        pvld;
        longint      acc;
        int unsigned cnt;
        logic        ovf;
        logic        busy;
    } exp_t;

    mdl_t m [N];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[dut%0d]: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    // Interpret the low w bits of v as a number in the cell's arithmetic.
    function automatic longint as_int(input logic [23:0] v, input int w, input int sg);
        longint r;
        r = longint'(v) & ((longint'(1) << w) - 1);
        if (sg != 0 && r[w-1]) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic longint opv(input logic [7:0] x, input int i);
        if (SG[i] != 0) return longint'($signed(x));
        return longint'(x);
    endfunction

    // Bring an exact sum into the accumulator's range: clamp or wrap.
    task automatic fit(input longint v, input int i, output longint r, output bit o);
        longint span, lo, hi;
        span = longint'(1) << AW[i];
        lo   = (SG[i] != 0) ? -(span / 2) : 0;
        hi   = lo + span - 1;
        o    = (v < lo) || (v > hi);
        if (!o)             r = v;
        else if (ST[i] != 0) r = (v > hi) ? hi : lo;
        else begin
            r = (v - lo) % span;
            if (r < 0) r = r + span;
            r = r + lo;
        end
    endtask

    task automatic model_step(input int i);
        exp_t   e;
        bit     act, qt, o, from_idle;
        int     ph, nxt;
        longint r;
        act       = a_vld_in || b_vld_in || w_load;
        qt        = !(act || psum_vld_in);
        from_idle = 1'b0;
        if (rst) begin
            m[i].st = P_IDLE; m[i].acc = 0; m[i].weight = 0; m[i].cnt = 0;
            m[i].ovf = 1'b0; m[i].quiet = 1'b0; m[i].psum = 0; m[i].pvld = 1'b0;
        end else begin
            ph = m[i].st;
            if (ph == P_IDLE && act) begin
                ph        = mode ? P_WS : P_OS;
                from_idle = 1'b1;
            end
            nxt = ph;
            if (ph != P_WS) m[i].quiet = 1'b0;
            case (ph)
                P_OS: begin
                    m[i].psum = as_int(psum_in, AW[i], SG[i]);
                    m[i].pvld = psum_vld_in;
                    if (a_vld_in && b_vld_in) begin
                        fit(m[i].acc + opv(a_in, i) * opv(b_in, i), i, r, o);
                        m[i].acc = r;
                        m[i].cnt++;
                        m[i].ovf = m[i].ovf | o;
                    end
                    if (drain && !from_idle) nxt = P_DRAIN;
                end
                P_WS: begin
                    if (w_load) begin
                        m[i].weight = opv(b_in, i);
                        m[i].pvld   = 1'b0;
                    end else if (a_vld_in) begin
                        fit((psum_vld_in ? as_int(psum_in, AW[i], SG[i]) : 0) + opv(a_in, i) * m[i].weight,
                            i, r, o);
                        m[i].psum = r;
                        m[i].pvld = 1'b1;
                        m[i].acc  = r;
                        m[i].cnt++;
                        m[i].ovf  = m[i].ovf | o;
                    end else begin
                        m[i].pvld = 1'b0;
                    end
                    if (qt && m[i].quiet) begin
                        nxt          = P_IDLE;
                        m[i].quiet   = 1'b0;
                    end else begin
                        m[i].quiet   = qt;
                    end
                end
                P_DRAIN: begin
                    m[i].psum = m[i].acc;
                    m[i].pvld = 1'b1;
                    m[i].acc  = 0;
                    if (psum_vld_in) m[i].ovf = 1'b1;
                    nxt = P_IDLE;
                end
                default: m[i].pvld = 1'b0;
            endcase
            m[i].st = nxt;
        end
        e.a    = rst ? 8'h00 : a_in;
        e.av   = rst ? 1'b0 : a_vld_in;
        e.b    = rst ? 8'h00 : b_in;
        e.bv   = rst ? 1'b0 : b_vld_in;
        e.psum = m[i].psum;
        e.pvld = m[i].pvld;
        e.acc  = m[i].acc;
        e.cnt  = m[i].cnt;
        e.ovf  = m[i].ovf;
        e.busy = (m[i].st != P_IDLE);
        sb.push_back(e);
    endtask

    // Inputs are already driven: predict, then let one clock edge pass.
    task automatic apply();
        for (int i = 0; i < N; i++) model_step(i);
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        rst = 1'b0; a_vld_in = 1'b0; b_vld_in = 1'b0; w_load = 1'b0;
        psum_vld_in = 1'b0; drain = 1'b0;
    endtask

    task automatic mac_in(input logic [7:0] a, input logic [7:0] b);
        quiet_inputs();
        a_in = a; b_in = b; a_vld_in = 1'b1; b_vld_in = 1'b1;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h7f;
            1:       return 8'h80;
            2:       return 8'hff;
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitor: every cycle the DUTs present outputs; compare against the queued prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() >= N) begin
            for (int i = 0; i < N; i++) begin
                e = sb.pop_front();
                check("a_out",     i, a_out_w[i], e.a);
                check("a_vld_out", i, a_vld_w[i], e.av);
                check("b_out",     i, b_out_w[i], e.b);
                check("b_vld_out", i, b_vld_w[i], e.bv);
                check("psum_out",  i, as_int(psum_w[i], AW[i], SG[i]), e.psum);
                check("psum_vld",  i, pvld_w[i], e.pvld);
                check("acc",       i, as_int(acc_w[i], AW[i], SG[i]), e.acc);
                check("mac_count", i, cnt_w[i], e.cnt);
                check("ovf",       i, ovf_w[i], e.ovf);
                check("busy",      i, busy_w[i], e.busy);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; a_in = '0; b_in = '0; psum_in = '0;
        a_vld_in = 1'b0; b_vld_in = 1'b0; w_load = 1'b0; psum_vld_in = 1'b0; drain = 1'b0;
        @(negedge clk);
        apply();
        apply();
        check("rst_busy", 0, busy_w[0], 0);
        check("rst_acc",  0, acc_w[0], 0);

        // Output-stationary accumulate and drain.
        mode = 1'b0;
        mac_in(8'd3, 8'd4);            apply(); check("os_acc1", 0, as_int(acc_w[0], 24, 1), 12);
        mac_in(8'hfe, 8'd5);           apply(); check("os_acc2", 0, as_int(acc_w[0], 24, 1), 2);
        mac_in(8'd7, 8'hff);           apply(); check("os_acc3", 0, as_int(acc_w[0], 24, 1), -5);
        quiet_inputs(); drain = 1'b1;  apply(); check("os_drain_busy", 0, busy_w[0], 1);
        quiet_inputs();                apply();
        check("os_psum",  0, as_int(psum_w[0], 24, 1), -5);
        check("os_pvld",  0, pvld_w[0], 1);
        check("os_acc0",  0, acc_w[0], 0);
        check("os_count", 0, cnt_w[0], 3);
        check("os_idle",  0, busy_w[0], 0);
        apply();
        check("os_pvld_one_cycle", 0, pvld_w[0], 0);

        // Weight-stationary: load weight, then one MAC with an upstream psum.
        mode = 1'b1;
        quiet_inputs(); w_load = 1'b1; b_in = 8'd6; b_vld_in = 1'b1; apply();
        quiet_inputs(); a_in = 8'd5; a_vld_in = 1'b1; psum_in = 24'd100; psum_vld_in = 1'b1; apply();
        check("ws_psum", 0, as_int(psum_w[0], 24, 1), 130);
        check("ws_pvld", 0, pvld_w[0], 1);
        quiet_inputs(); apply();
        check("ws_pvld_drop", 0, pvld_w[0], 0);
        check("ws_busy1", 0, busy_w[0], 1);
        apply();
        check("ws_to_idle", 0, busy_w[0], 0);
        quiet_inputs(); a_in = 8'd2; a_vld_in = 1'b1; apply();
        check("ws_weight_kept", 0, as_int(psum_w[0], 24, 1), 12);

        // Saturation / wrap with 16-bit accumulators.
        quiet_inputs(); rst = 1'b1; apply();
        mode = 1'b0;
        for (int k = 0; k < 3; k++) begin mac_in(8'd127, 8'd127); apply(); end
        check("sat_clamp", 1, as_int(acc_w[1], 16, 1), 32767);
        check("sat_ovf",   1, ovf_w[1], 1);
        check("wrap_acc",  2, as_int(acc_w[2], 16, 1), -17149);
        check("wrap_ovf",  2, ovf_w[2], 1);
        check("wide_ovf",  0, ovf_w[0], 0);
        for (int k = 0; k < 2; k++) begin mac_in(8'd127, 8'd127); apply(); end
        check("sat_hold",      1, as_int(acc_w[1], 16, 1), 32767);
        check("sat_ovf_stay",  1, ovf_w[1], 1);
        check("wrap_acc2",     2, as_int(acc_w[2], 16, 1), 15109);
        check("usat_clamp",    3, as_int(acc_w[3], 16, 0), 65535);
        check("wide_acc",      0, as_int(acc_w[0], 24, 1), 80645);

        // Drain with an incoming psum: passthrough first, then own acc, incoming dropped.
        quiet_inputs(); drain = 1'b1; psum_in = 24'd777; psum_vld_in = 1'b1; apply();
        check("drain_pass", 0, as_int(psum_w[0], 24, 1), 777);
        quiet_inputs(); psum_in = 24'd777; psum_vld_in = 1'b1; apply();
        check("drain_own",  0, as_int(psum_w[0], 24, 1), 80645);
        check("drain_pvld", 0, pvld_w[0], 1);
        check("drain_ovf",  0, ovf_w[0], 1);

        // Reset in the middle of an OS run overrides a simultaneous MAC.
        quiet_inputs(); rst = 1'b1; apply();
        mac_in(8'd5, 8'd10); apply();
        check("pre_rst_acc", 0, as_int(acc_w[0], 24, 1), 50);
        mac_in(8'd3, 8'd3); rst = 1'b1; apply();
        check("rst_acc0",  0, acc_w[0], 0);
        check("rst_busy0", 0, busy_w[0], 0);
        check("rst_aout",  0, a_out_w[0], 0);
        check("rst_avld",  0, a_vld_w[0], 0);
        check("rst_cnt",   0, cnt_w[0], 0);
        check("rst_ovf",   0, ovf_w[0], 0);
        mac_in(8'd2, 8'd3); apply();
        check("post_rst_acc", 0, as_int(acc_w[0], 24, 1), 6);
        check("post_rst_cnt", 0, cnt_w[0], 1);

        // Randomized traffic across modes, with gaps, drains, weight loads and rare resets.
        for (int c = 0; c < 2000; c++) begin
            quiet_inputs();
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            if ($urandom_range(0, 4) != 0) begin
                a_vld_in    = ($urandom_range(0, 9) < 6);
                b_vld_in    = ($urandom_range(0, 9) < 6);
                w_load      = ($urandom_range(0, 9) == 0);
                psum_vld_in = ($urandom_range(0, 9) < 4);
                drain       = ($urandom_range(0, 11) == 0);
            end
            a_in    = pick();
            b_in    = pick();
            psum_in = 24'($urandom);
            apply();
        end

        quiet_inputs();
        apply();
        check("scoreboard_empty", 0, sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
